// File: rtl/power_seq_pkg.sv
// rtl/power_seq_pkg.sv - shared encodings and width helpers for the rail sequencer
package power_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_UP         = 3'd1,
    ST_ON         = 3'd2,
    ST_DOWN       = 3'd3,
    ST_FAULT_DOWN = 3'd4
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_START_TO = 2'b01;
  localparam logic [1:0] FC_DROP     = 2'b10;
  localparam logic [1:0] FC_STOP_TO  = 2'b11;

  function automatic int unsigned width_for(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

  localparam int unsigned IDX_W   = width_for(15);
  localparam int unsigned TIMER_W = width_for(255);
  localparam int unsigned DEB_W   = width_for(15);

endpackage

// File: rtl/rail_debounce.sv
// rtl/rail_debounce.sv - per-rail power-good synchroniser and tick-based debounce
module rail_debounce
  import power_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic sysclk,
  input  logic reset,
  input  logic tick,
  input  logic raw_good,
  output logic ok
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_TICKS);

  logic             sync1_q;
  logic             sync2_q;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;

  // A single low sample discards all accumulated good time.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != DEB_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_good;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  assign ok = (cnt_q == DEB_MAX);

endmodule

// File: rtl/power_rail_sequencer.sv
// rtl/power_rail_sequencer.sv - N-rail ordered power-up / reverse power-down sequencer
module power_rail_sequencer
  import power_seq_pkg::*;
#(
  parameter int unsigned NUM_RAILS      = 4,
  parameter int unsigned TICK_DIV       = 500,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned TIMEOUT_TICKS  = 255,
  parameter int unsigned HOLDOFF_TICKS  = 250
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_RAILS-1:0] rail_good,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 all_good,
  output logic                 fault,
  output logic [1:0]           fault_code,
  output logic [3:0]           fault_rail,
  output logic [2:0]           state,
  output logic [3:0]           rail_idx
);

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [TIMER_W-1:0] tmr_t;

  localparam int unsigned    PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam idx_t           LAST_IDX = idx_t'(NUM_RAILS - 1);
  localparam tmr_t           TO_LIM   = tmr_t'(TIMEOUT_TICKS);
  localparam tmr_t           HOLD_LIM = tmr_t'(HOLDOFF_TICKS);
  localparam tmr_t           TMR_SAT  = '1;

  state_e               state_q, state_d;
  idx_t                 idx_q, idx_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  tmr_t                 timer_q, timer_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic                 all_good_q, all_good_d;
  logic                 fault_q, fault_d;
  logic [1:0]           fcode_q, fcode_d;
  idx_t                 frail_q, frail_d;

  logic                 tick;
  logic                 to;
  logic [NUM_RAILS-1:0] ok;
  logic [15:0]          ok_ext;
  logic                 bad_below, bad_any;
  idx_t                 bad_below_idx, bad_any_idx;

  assign tick   = (pre_q == PRE_LAST);
  assign pre_d  = tick ? '0 : pre_q + 1'b1;
  assign to     = (timer_q >= TO_LIM);
  assign ok_ext = 16'(ok);

  for (genvar g = 0; g < NUM_RAILS; g++) begin : g_deb
    rail_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
      .sysclk  (sysclk),
      .reset   (reset),
      .tick    (tick),
      .raw_good(rail_good[g]),
      .ok      (ok[g])
    );
  end

  // Descending scan so the last hit is the lowest failing rail.
  always_comb begin
    bad_below     = 1'b0;
    bad_below_idx = '0;
    bad_any       = 1'b0;
    bad_any_idx   = '0;
    for (int k = NUM_RAILS - 1; k >= 0; k--) begin
      if (!ok[k]) begin
        bad_any     = 1'b1;
        bad_any_idx = idx_t'(k);
        if (idx_t'(k) < idx_q) begin
          bad_below     = 1'b1;
          bad_below_idx = idx_t'(k);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fault_d = fault_q;
    fcode_d = fcode_q;
    frail_d = frail_q;
    case (state_q)
      ST_OFF: begin
        if (enable && (timer_q >= HOLD_LIM)) begin
          state_d = ST_UP;
          idx_d   = '0;
          fault_d = 1'b0;
          fcode_d = FC_NONE;
          frail_d = '0;
        end
      end
      ST_UP: begin
        if (bad_below) begin
          state_d = ST_FAULT_DOWN;
          fault_d = 1'b1;
          fcode_d = FC_DROP;
          frail_d = bad_below_idx;
        end else if (to) begin
          state_d = ST_FAULT_DOWN;
          fault_d = 1'b1;
          fcode_d = FC_START_TO;
          frail_d = idx_q;
        end else if (!enable) begin
          state_d = ST_DOWN;
        end else if (ok_ext[idx_q]) begin
          if (idx_q == LAST_IDX) state_d = ST_ON;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_ON: begin
        if (bad_any) begin
          state_d = ST_FAULT_DOWN;
          idx_d   = LAST_IDX;
          fault_d = 1'b1;
          fcode_d = FC_DROP;
          frail_d = bad_any_idx;
        end else if (!enable) begin
          state_d = ST_DOWN;
          idx_d   = LAST_IDX;
        end
      end
      ST_DOWN, ST_FAULT_DOWN: begin
        if (!ok_ext[idx_q] || to) begin
          // Still good at the deadline: a rail that refuses to turn off.
          if (ok_ext[idx_q]) begin
            fault_d = 1'b1;
            if (!fault_q) begin
              fcode_d = FC_STOP_TO;
              frail_d = idx_q;
            end
          end
          if (idx_q == '0) state_d = ST_OFF;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_DOWN;
        idx_d   = LAST_IDX;
      end
    endcase
  end

  always_comb begin
    rail_en_d = '0;
    for (int k = 0; k < NUM_RAILS; k++) begin
      case (state_d)
        ST_UP:                  rail_en_d[k] = (idx_t'(k) <= idx_d);
        ST_ON:                  rail_en_d[k] = 1'b1;
        ST_DOWN, ST_FAULT_DOWN: rail_en_d[k] = (idx_t'(k) < idx_d);
        default:                rail_en_d[k] = 1'b0;
      endcase
    end
    all_good_d = (state_d == ST_ON);
    timer_d    = timer_q;
    if ((state_d != state_q) || (idx_d != idx_q)) begin
      timer_d = '0;
    end else if (tick && (timer_q != TMR_SAT)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= ST_OFF;
      idx_q      <= '0;
      pre_q      <= '0;
      timer_q    <= HOLD_LIM;
      rail_en_q  <= '0;
      all_good_q <= 1'b0;
      fault_q    <= 1'b0;
      fcode_q    <= FC_NONE;
      frail_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pre_q      <= pre_d;
      timer_q    <= timer_d;
      rail_en_q  <= rail_en_d;
      all_good_q <= all_good_d;
      fault_q    <= fault_d;
      fcode_q    <= fcode_d;
      frail_q    <= frail_d;
    end
  end

  assign rail_en    = rail_en_q;
  assign all_good   = all_good_q;
  assign fault      = fault_q;
  assign fault_code = fcode_q;
  assign fault_rail = 4'(frail_q);
  assign state      = state_q;
  assign rail_idx   = 4'(idx_q);

endmodule

// File: tb/tb_power_rail_sequencer.sv
// tb/tb_power_rail_sequencer.sv - directed self-checking bench for power_rail_sequencer
module tb_power_rail_sequencer;

  localparam int N = 3;

  logic         sysclk = 1'b0;
  logic         reset;
  logic         enable;
  logic [N-1:0] rail_good;
  logic [N-1:0] rail_en;
  logic         all_good;
  logic         fault;
  logic [1:0]   fault_code;
  logic [3:0]   fault_rail;
  logic [2:0]   state;
  logic [3:0]   rail_idx;

  logic [N-1:0] good_base  = '0;
  logic [N-1:0] stuck_good = '0;
  logic [N-1:0] stuck_bad  = '0;
  logic [N-1:0] glitch     = '0;
  int           dly [N];
  logic [N-1:0] last_en;
  int           n_pass  = 0;
  int           n_total = 0;

  always #5 sysclk = ~sysclk;

  power_rail_sequencer #(
    .NUM_RAILS     (N),
    .TICK_DIV      (4),
    .DEBOUNCE_TICKS(2),
    .TIMEOUT_TICKS (8),
    .HOLDOFF_TICKS (5)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .enable    (enable),
    .rail_good (rail_good),
    .rail_en   (rail_en),
    .all_good  (all_good),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_rail(fault_rail),
    .state     (state),
    .rail_idx  (rail_idx)
  );

  // Board: each rail reports good 3 ticks (12 sysclk) after its enable, drops with it.
  always @(posedge sysclk) begin
    for (int k = 0; k < N; k++) begin
      if (rail_en[k] !== 1'b1) begin
        dly[k]       <= 0;
        good_base[k] <= 1'b0;
      end else if (dly[k] < 12) begin
        dly[k] <= dly[k] + 1;
      end else begin
        good_base[k] <= 1'b1;
      end
    end
  end

  assign rail_good = (good_base | stuck_good) & ~stuck_bad & ~glitch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (state !== st && n < budget) begin
      step();
      n++;
    end
    if (state !== st) check({tag, "_timeout"}, 32'(state), 32'(st));
  endtask

  task automatic wait_idx(input string tag, input logic [3:0] idx, input int budget, output int n);
    n = 0;
    while (rail_idx !== idx && n < budget) begin
      step();
      n++;
    end
    if (rail_idx !== idx) check({tag, "_timeout"}, 32'(rail_idx), 32'(idx));
  endtask

  task automatic next_en(input string tag, input logic [N-1:0] exp);
    int n;
    n = 0;
    while (rail_en === last_en && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(rail_en), 32'(exp));
    last_en = rail_en;
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) step();
    check("rst_rail_en", 32'(rail_en), 0);
    check("rst_all_good", 32'(all_good), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_code", 32'(fault_code), 0);
    check("rst_frail", 32'(fault_rail), 0);
    check("rst_state", 32'(state), 0);
    check("rst_idx", 32'(rail_idx), 0);
    reset   = 1'b0;
    last_en = rail_en;

    // Nominal startup: first start is immediate because the timer resets to holdoff.
    enable = 1'b1;
    next_en("nom_en0", 3'b001);
    next_en("nom_en1", 3'b011);
    next_en("nom_en2", 3'b111);
    wait_state("nom_on", 3'd2, 100, n);
    check("nom_all_good", 32'(all_good), 1);
    check("nom_fault", 32'(fault), 0);

    // One-cycle drop on rail 0 while ON.
    glitch[0] = 1'b1;
    step();
    glitch[0] = 1'b0;
    wait_state("drop_fd", 3'd4, 20, n);
    check("drop_code", 32'(fault_code), 2);
    check("drop_frail", 32'(fault_rail), 0);
    check("drop_fault", 32'(fault), 1);
    check("drop_idx", 32'(rail_idx), 2);
    enable = 1'b0;
    next_en("drop_en2", 3'b011);
    next_en("drop_en1", 3'b001);
    next_en("drop_en0", 3'b000);
    wait_state("drop_off", 3'd0, 40, n);
    check("drop_sticky", 32'(fault), 1);
    check("drop_sticky_code", 32'(fault_code), 2);

    // Normal shutdown followed by an immediate re-enable.
    enable = 1'b1;
    wait_state("ns_up", 3'd1, 100, n);
    check("ns_fault_clr", 32'(fault), 0);
    wait_state("ns_on", 3'd2, 100, n);
    last_en = rail_en;
    enable  = 1'b0;
    wait_state("ns_down", 3'd3, 10, n);
    check("ns_idx", 32'(rail_idx), 2);
    next_en("ns_en2", 3'b011);
    next_en("ns_en1", 3'b001);
    next_en("ns_en0", 3'b000);
    wait_state("ns_off", 3'd0, 40, n);
    enable = 1'b1;
    wait_state("ho_up", 3'd1, 60, n);
    check("ho_min", 32'(n >= 18), 1);
    check("ho_max", 32'(n <= 21), 1);
    check("ho_fault", 32'(fault), 0);

    // Rail 2 refuses to drop during shutdown.
    wait_state("sdto_on", 3'd2, 100, n);
    stuck_good[2] = 1'b1;
    enable        = 1'b0;
    wait_state("sdto_down", 3'd3, 10, n);
    wait_idx("sdto_idx1", 4'd1, 60, n);
    check("sdto_min", 32'(n >= 30), 1);
    check("sdto_max", 32'(n <= 33), 1);
    check("sdto_code", 32'(fault_code), 3);
    check("sdto_frail", 32'(fault_rail), 2);
    check("sdto_fault", 32'(fault), 1);
    check("sdto_state", 32'(state), 3);
    check("sdto_en", 32'(rail_en), 32'(3'b001));
    wait_state("sdto_off", 3'd0, 40, n);
    check("sdto_sticky", 32'(fault), 1);
    stuck_good[2] = 1'b0;

    // Rail 1 never comes good.
    stuck_bad[1] = 1'b1;
    enable       = 1'b1;
    wait_state("st_up", 3'd1, 100, n);
    check("st_fault_clr", 32'(fault), 0);
    check("st_code_clr", 32'(fault_code), 0);
    wait_idx("st_idx1", 4'd1, 60, n);
    check("st_en1", 32'(rail_en), 32'(3'b011));
    wait_state("st_fd", 3'd4, 60, n);
    check("st_min", 32'(n >= 30), 1);
    check("st_max", 32'(n <= 33), 1);
    check("st_code", 32'(fault_code), 1);
    check("st_frail", 32'(fault_rail), 1);
    check("st_fault", 32'(fault), 1);
    check("st_en_fd", 32'(rail_en), 32'(3'b001));
    enable  = 1'b0;
    last_en = rail_en;
    next_en("st_en0", 3'b000);
    wait_state("st_off", 3'd0, 40, n);
    check("st_off_state", 32'(state), 0);
    stuck_bad[1] = 1'b0;

    // Reset in the middle of power-up.
    enable = 1'b1;
    wait_idx("rst_up_idx1", 4'd1, 100, n);
    check("rst_up_state", 32'(state), 1);
    reset = 1'b1;
    step();
    check("rstm_rail_en", 32'(rail_en), 0);
    check("rstm_state", 32'(state), 0);
    check("rstm_idx", 32'(rail_idx), 0);
    check("rstm_all_good", 32'(all_good), 0);
    check("rstm_fault", 32'(fault), 0);
    check("rstm_code", 32'(fault_code), 0);
    enable = 1'b0;
    reset  = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
